ga_sync_int: RTL and testbench
==============================

GA_SYNC_INT -- requirements
Module: ga_sync_int

Interface
REQ-001 SHALL have parameter HSYNC_DELAY, default 2: chars from CRTC HSYNC rise to monitor HSYNC start.
REQ-002 SHALL have parameter HSYNC_MAX, default 4: maximum monitor HSYNC width in chars.
REQ-003 SHALL have parameter VSYNC_LINES, default 26: maximum monitor VSYNC width in HSYNC falls.
REQ-004 SHALL have parameter INT_LINES, default 52: interrupt period in HSYNC falls.
REQ-005 SHALL have port CLOCK  in  1  system clock; the block uses one clock only.
REQ-006 SHALL have port nRESET  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port CLKEN  in  1  char enable (1 MHz), same strobe that drives the CRTC.
REQ-008 SHALL have port HSYNC_IN  in  1  CRTC HSYNC.
REQ-009 SHALL have port VSYNC_IN  in  1  CRTC VSYNC.
REQ-010 SHALL have port INT_ACK  in  1  one-CLOCK Z80 interrupt-acknowledge strobe.
REQ-011 SHALL have port INT_CLR  in  1  one-CLOCK strobe for an RMR write with bit 4 set.
REQ-012 SHALL have port MODE_WE  in  1  one-CLOCK strobe for an RMR write.
REQ-013 SHALL have port MODE_DI  in  2  requested screen mode.
REQ-014 SHALL have port INT  out  1  Z80 interrupt request, level.
REQ-015 SHALL have port HSYNC_OUT  out  1  monitor HSYNC.
REQ-016 SHALL have port VSYNC_OUT  out  1  monitor VSYNC.
REQ-017 SHALL have port CSYNC  out  1  HSYNC_OUT OR VSYNC_OUT.
REQ-018 SHALL have port MODE  out  2  effective screen mode.
REQ-019 SHALL have port R52  out  6  interrupt line counter, for debug/status.

Function
REQ-020 SHALL register HSYNC_IN and VSYNC_IN only on CLKEN; all rise/fall events are detected on CLKEN cycles.
REQ-021 SHALL handle CPU strobes (INT_ACK, INT_CLR, MODE_WE) on any CLOCK cycle, independent of CLKEN.
REQ-022 SHALL hold MODE_DI in a pending register on MODE_WE and copy it to MODE on the next HSYNC_IN rise.
REQ-023 SHALL increment R52 on each HSYNC_IN fall; when the increment reaches INT_LINES, SHALL set R52 to 0 and set INT to 1.
REQ-024 SHALL arm a 2-count delay on a VSYNC_IN rise and decrement it on each HSYNC_IN fall; on the fall that brings it to 0, SHALL set R52 to 0 and set INT to 1 only if R52 >= 32 before that fall.
REQ-025 SHALL treat a VSYNC-reset and an INT_LINES wrap on the same fall as one event: R52 = 0, INT = 1.
REQ-026 SHALL, on INT_ACK alone, set INT to 0 and R52[5] to 0.
REQ-027 SHALL, when INT_ACK coincides with an INT-setting event, leave INT = 1 and R52 = 0.
REQ-028 SHALL, when INT_ACK coincides with a plain HSYNC fall, give R52 = (R52 & 0x1F) + 1.
REQ-029 SHALL give INT_CLR highest priority: R52 = 0 and INT = 0, regardless of any coincident event.
REQ-030 SHALL assert HSYNC_OUT on the CLKEN HSYNC_DELAY chars after the HSYNC_IN rise, provided HSYNC_IN is still high.
REQ-031 SHALL deassert HSYNC_OUT after HSYNC_MAX chars or on the first CLKEN that samples HSYNC_IN low, whichever comes first.
REQ-032 SHALL restart the HSYNC delay on a new HSYNC_IN rise during the delay.
REQ-033 SHALL assert VSYNC_OUT on the CLKEN that detects a VSYNC_IN rise.
REQ-034 SHALL deassert VSYNC_OUT after VSYNC_LINES HSYNC_IN falls or on a VSYNC_IN fall, whichever comes first.
REQ-035 SHALL NOT retrigger VSYNC_OUT while VSYNC_IN stays high.
REQ-036 SHALL compute CSYNC combinationally; all other outputs are registered.

Reset
REQ-037 SHALL, on nRESET low, immediately clear INT, HSYNC_OUT, VSYNC_OUT, MODE, R52, the pending mode, the delay counters, and the sampled sync registers.
REQ-038 SHALL restart cleanly when reset is released mid-sync: a sync input already high is not treated as a rise until it has been seen low.

Structure
REQ-039 SHALL place parameter defaults and the INT threshold constant (32) in the shared ga_pkg package.
REQ-040 SHALL use no sub-module; an optional edge-detect helper is named sync_edge.

Verification
REQ-041 SHALL cover: 104 HSYNC falls with no VSYNC -> INT rises at falls 52 and 104, R52 = 0 each time.
REQ-042 SHALL cover: VSYNC rise at R52 = 40, then 2 HSYNC falls -> INT = 1 and R52 = 0 at the 2nd fall.
REQ-043 SHALL cover: VSYNC rise at R52 = 20 -> no INT and R52 = 0 at the 2nd fall.
REQ-044 SHALL cover: INT_ACK while INT = 1 at R52 = 37 -> INT = 0 and R52 = 5; INT_CLR coincident with the 52nd fall -> INT = 0 and R52 = 0.
REQ-045 SHALL cover: CRTC HSYNC width 14 -> HSYNC_OUT high 4 chars starting 2 chars after the rise; width 3 -> HSYNC_OUT 1 char; width 2 -> no HSYNC_OUT.
REQ-046 SHALL cover: MODE_WE 2 mid-line -> MODE stays at its old value until the next HSYNC_IN rise; VSYNC_IN width 16 lines -> VSYNC_OUT 16 lines; width 31 -> VSYNC_OUT 26 lines.

Source files
------------

// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared defaults and constants for the gate-array sync/interrupt block
package ga_pkg;
   localparam int HSYNC_DELAY_DEF = 2;
   localparam int HSYNC_MAX_DEF   = 4;
   localparam int VSYNC_LINES_DEF = 26;
   localparam int INT_LINES_DEF   = 52;
   localparam int INT_THRESHOLD   = 32;

   typedef logic [1:0] mode_t;
endpackage

// File: rtl/ga_sync_int.sv
// rtl/ga_sync_int.sv - monitor sync generation, 52-line interrupt counter and mode latch
module ga_sync_int
   import ga_pkg::*;
#(
   parameter int HSYNC_DELAY = HSYNC_DELAY_DEF,
   parameter int HSYNC_MAX   = HSYNC_MAX_DEF,
   parameter int VSYNC_LINES = VSYNC_LINES_DEF,
   parameter int INT_LINES   = INT_LINES_DEF
) (
   input  logic       CLOCK,
   input  logic       nRESET,
   input  logic       CLKEN,
   input  logic       HSYNC_IN,
   input  logic       VSYNC_IN,
   input  logic       INT_ACK,
   input  logic       INT_CLR,
   input  logic       MODE_WE,
   input  logic [1:0] MODE_DI,
   output logic       INT,
   output logic       HSYNC_OUT,
   output logic       VSYNC_OUT,
   output logic       CSYNC,
   output logic [1:0] MODE,
   output logic [5:0] R52
);
   localparam int HDW = $clog2(HSYNC_DELAY + 1);
   localparam int HMW = $clog2(HSYNC_MAX + 1);
   localparam int VLW = $clog2(VSYNC_LINES + 1);

   logic           hs_q, hs_d, vs_q, vs_d;
   logic           hs_arm_q, hs_arm_d, vs_arm_q, vs_arm_d;
   logic [HDW-1:0] hdly_q, hdly_d;
   logic [HMW-1:0] hwid_q, hwid_d;
   logic           hsync_out_q, hsync_out_d;
   logic [VLW-1:0] vcnt_q, vcnt_d;
   logic           vsync_out_q, vsync_out_d;
   logic [1:0]     vdly_q, vdly_d;
   logic [5:0]     r52_q, r52_d;
   logic           int_q, int_d;
   mode_t          mode_q, mode_d, mode_pend_q, mode_pend_d;

   logic           hs_rise, hs_fall, vs_rise, vs_fall;
   logic           vsync_rst, wrap, set_int;
   logic [6:0]     r52_inc;
   logic [5:0]     r52_ack;

   // A sync input seen high straight out of reset is ignored until it has been low once.
   assign hs_rise = CLKEN & HSYNC_IN & hs_arm_q & ~hs_q;
   assign hs_fall = CLKEN & ~HSYNC_IN & hs_q;
   assign vs_rise = CLKEN & VSYNC_IN & vs_arm_q & ~vs_q;
   assign vs_fall = CLKEN & ~VSYNC_IN & vs_q;

   assign vsync_rst = hs_fall & (vdly_q == 2'd1);
   assign r52_inc   = {1'b0, r52_q} + 7'd1;
   assign r52_ack   = {1'b0, r52_q[4:0]};
   assign wrap      = (r52_inc == 7'(INT_LINES));
   assign set_int   = hs_fall & (wrap | (vsync_rst & (r52_q >= 6'(INT_THRESHOLD))));

   always_comb begin
      hs_d     = hs_q;
      vs_d     = vs_q;
      hs_arm_d = hs_arm_q | (CLKEN & ~HSYNC_IN);
      vs_arm_d = vs_arm_q | (CLKEN & ~VSYNC_IN);
      if (CLKEN) begin
         hs_d = HSYNC_IN & hs_arm_q;
         vs_d = VSYNC_IN & vs_arm_q;
      end
   end

   always_comb begin
      hdly_d      = hdly_q;
      hwid_d      = hwid_q;
      hsync_out_d = hsync_out_q;
      if (CLKEN) begin
         if (hs_rise) begin
            hdly_d = HDW'(HSYNC_DELAY);
         end else if (hdly_q != '0) begin
            if (!HSYNC_IN) begin
               hdly_d = '0;
            end else if (hdly_q == HDW'(1)) begin
               hdly_d      = '0;
               hsync_out_d = 1'b1;
               hwid_d      = HMW'(HSYNC_MAX);
            end else begin
               hdly_d = hdly_q - HDW'(1);
            end
         end
         if (hsync_out_q) begin
            if (!HSYNC_IN || hwid_q == HMW'(1)) begin
               hsync_out_d = 1'b0;
            end else begin
               hwid_d = hwid_q - HMW'(1);
            end
         end
      end
   end

   always_comb begin
      vcnt_d      = vcnt_q;
      vsync_out_d = vsync_out_q;
      vdly_d      = vdly_q;
      if (vs_rise) begin
         vsync_out_d = 1'b1;
         vcnt_d      = VLW'(VSYNC_LINES);
      end else if (vs_fall) begin
         vsync_out_d = 1'b0;
      end else if (vsync_out_q && hs_fall) begin
         if (vcnt_q == VLW'(1)) begin
            vsync_out_d = 1'b0;
         end else begin
            vcnt_d = vcnt_q - VLW'(1);
         end
      end
      if (vs_rise) begin
         vdly_d = 2'd2;
      end else if (hs_fall && vdly_q != 2'd0) begin
         vdly_d = vdly_q - 2'd1;
      end
   end

   // Acknowledge first, line event overrides it, INT_CLR overrides everything.
   always_comb begin
      int_d = int_q;
      r52_d = r52_q;
      if (INT_ACK) begin
         int_d = 1'b0;
         r52_d = r52_ack;
      end
      if (hs_fall) begin
         if (set_int) begin
            int_d = 1'b1;
            r52_d = '0;
         end else if (vsync_rst) begin
            r52_d = '0;
         end else begin
            r52_d = (INT_ACK ? r52_ack : r52_q) + 6'd1;
         end
      end
      if (INT_CLR) begin
         int_d = 1'b0;
         r52_d = '0;
      end
   end

   always_comb begin
      mode_pend_d = MODE_WE ? MODE_DI : mode_pend_q;
      mode_d      = hs_rise ? mode_pend_q : mode_q;
   end

   always_ff @(posedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         hs_arm_q    <= 1'b0;
         vs_arm_q    <= 1'b0;
         hdly_q      <= '0;
         hwid_q      <= '0;
         hsync_out_q <= 1'b0;
         vcnt_q      <= '0;
         vsync_out_q <= 1'b0;
         vdly_q      <= '0;
         r52_q       <= '0;
         int_q       <= 1'b0;
         mode_q      <= '0;
         mode_pend_q <= '0;
      end else begin
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         hs_arm_q    <= hs_arm_d;
         vs_arm_q    <= vs_arm_d;
         hdly_q      <= hdly_d;
         hwid_q      <= hwid_d;
         hsync_out_q <= hsync_out_d;
         vcnt_q      <= vcnt_d;
         vsync_out_q <= vsync_out_d;
         vdly_q      <= vdly_d;
         r52_q       <= r52_d;
         int_q       <= int_d;
         mode_q      <= mode_d;
         mode_pend_q <= mode_pend_d;
      end
   end

   assign INT       = int_q;
   assign HSYNC_OUT = hsync_out_q;
   assign VSYNC_OUT = vsync_out_q;
   assign CSYNC     = hsync_out_q | vsync_out_q;
   assign MODE      = mode_q;
   assign R52       = r52_q;
endmodule

// File: tb/tb_ga_sync_int.sv
// tb/tb_ga_sync_int.sv - directed self-checking bench for ga_sync_int
module tb_ga_sync_int;
   logic       CLOCK = 1'b0;
   logic       nRESET, CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR, MODE_WE;
   logic [1:0] MODE_DI;
   logic       INT, HSYNC_OUT, VSYNC_OUT, CSYNC;
   logic [1:0] MODE;
   logic [5:0] R52;
   int         checks = 0;
   int         errors = 0;
   logic       vs_lvl = 1'b0;

   always #5 CLOCK = ~CLOCK;

   ga_sync_int dut (
      .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .HSYNC_IN(HSYNC_IN),
      .VSYNC_IN(VSYNC_IN), .INT_ACK(INT_ACK), .INT_CLR(INT_CLR), .MODE_WE(MODE_WE),
      .MODE_DI(MODE_DI), .INT(INT), .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT),
      .CSYNC(CSYNC), .MODE(MODE), .R52(R52)
   );

   task automatic char_tick(input logic hs, input logic vs, input logic ack, input logic clr);
      @(negedge CLOCK);
      HSYNC_IN = hs; VSYNC_IN = vs; INT_ACK = ack; INT_CLR = clr; CLKEN = 1'b1;
      @(negedge CLOCK);
      CLKEN = 1'b0; INT_ACK = 1'b0; INT_CLR = 1'b0;
   endtask

   task automatic line();
      char_tick(1'b1, vs_lvl, 1'b0, 1'b0);
      char_tick(1'b0, vs_lvl, 1'b0, 1'b0);
   endtask

   task automatic lines(input int n);
      for (int i = 0; i < n; i++) line();
   endtask

   task automatic ack_strobe();
      @(negedge CLOCK); INT_ACK = 1'b1;
      @(negedge CLOCK); INT_ACK = 1'b0;
   endtask

   task automatic test_reset();
      nRESET = 1'b0; CLKEN = 1'b0; HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;
      INT_ACK = 1'b0; INT_CLR = 1'b0; MODE_WE = 1'b0; MODE_DI = 2'd0;
      char_tick(1'b1, 1'b1, 1'b0, 1'b0);
      char_tick(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", INT); end
      checks++; if (HSYNC_OUT !== 1'b0 || VSYNC_OUT !== 1'b0 || CSYNC !== 1'b0) begin
         errors++; $display("FAIL reset_sync got h%b v%b c%b exp 000", HSYNC_OUT, VSYNC_OUT, CSYNC); end
      checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", MODE); end
      checks++; if (R52 !== 6'd0) begin errors++; $display("FAIL reset_r52 got %0d exp 0", R52); end
      @(negedge CLOCK); nRESET = 1'b1;
      for (int k = 0; k < 5; k++) begin
         char_tick(1'b1, 1'b1, 1'b0, 1'b0);
         checks++; if (HSYNC_OUT !== 1'b0 || VSYNC_OUT !== 1'b0) begin
            errors++; $display("FAIL release_high char %0d got h%b v%b exp h0 v0", k, HSYNC_OUT, VSYNC_OUT); end
      end
      char_tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (R52 !== 6'd0) begin errors++; $display("FAIL release_fall_r52 got %0d exp 0", R52); end
   endtask

   task automatic test_int_period();
      for (int i = 1; i <= 104; i++) begin
         line();
         checks++;
         if (i == 52 || i == 104) begin
            if (INT !== 1'b1 || R52 !== 6'd0) begin
               errors++; $display("FAIL int_wrap fall %0d got int %b r52 %0d exp int 1 r52 0", i, INT, R52); end
            ack_strobe();
            checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_wrap_ack got %b exp 0", INT); end
         end else if (INT !== 1'b0 || R52 !== 6'(i % 52)) begin
            errors++; $display("FAIL int_count fall %0d got int %b r52 %0d exp int 0 r52 %0d", i, INT, R52, i % 52);
         end
      end
   endtask

   task automatic test_vsync_int();
      lines(40);
      checks++; if (R52 !== 6'd40) begin errors++; $display("FAIL vint_pre got %0d exp 40", R52); end
      vs_lvl = 1'b1; char_tick(1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (VSYNC_OUT !== 1'b1 || CSYNC !== 1'b1) begin
         errors++; $display("FAIL vint_vsout got v%b c%b exp 11", VSYNC_OUT, CSYNC); end
      line();
      checks++; if (INT !== 1'b0 || R52 !== 6'd41) begin
         errors++; $display("FAIL vint_fall1 got int %b r52 %0d exp int 0 r52 41", INT, R52); end
      line();
      checks++; if (INT !== 1'b1 || R52 !== 6'd0) begin
         errors++; $display("FAIL vint_fall2 got int %b r52 %0d exp int 1 r52 0", INT, R52); end
      vs_lvl = 1'b0; char_tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (VSYNC_OUT !== 1'b0) begin errors++; $display("FAIL vint_vsfall got %b exp 0", VSYNC_OUT); end
      ack_strobe();
   endtask

   task automatic test_vsync_low();
      lines(20);
      vs_lvl = 1'b1; char_tick(1'b0, 1'b1, 1'b0, 1'b0);
      line();
      checks++; if (R52 !== 6'd21) begin errors++; $display("FAIL vlow_fall1 got %0d exp 21", R52); end
      line();
      checks++; if (INT !== 1'b0 || R52 !== 6'd0) begin
         errors++; $display("FAIL vlow_fall2 got int %b r52 %0d exp int 0 r52 0", INT, R52); end
      vs_lvl = 1'b0; char_tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_ack_clr();
      lines(52);
      lines(37);
      checks++; if (INT !== 1'b1 || R52 !== 6'd37) begin
         errors++; $display("FAIL ack_pre got int %b r52 %0d exp int 1 r52 37", INT, R52); end
      ack_strobe();
      checks++; if (INT !== 1'b0 || R52 !== 6'd5) begin
         errors++; $display("FAIL ack_alone got int %b r52 %0d exp int 0 r52 5", INT, R52); end
      lines(46);
      char_tick(1'b1, 1'b0, 1'b0, 1'b0); char_tick(1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (INT !== 1'b0 || R52 !== 6'd0) begin
         errors++; $display("FAIL clr_wrap got int %b r52 %0d exp int 0 r52 0", INT, R52); end
      lines(40);
      char_tick(1'b1, 1'b0, 1'b0, 1'b0); char_tick(1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (INT !== 1'b0 || R52 !== 6'd9) begin
         errors++; $display("FAIL ack_plain_fall got int %b r52 %0d exp int 0 r52 9", INT, R52); end
      lines(42);
      char_tick(1'b1, 1'b0, 1'b0, 1'b0); char_tick(1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (INT !== 1'b1 || R52 !== 6'd0) begin
         errors++; $display("FAIL ack_int_fall got int %b r52 %0d exp int 1 r52 0", INT, R52); end
      ack_strobe();
      lines(50);
      vs_lvl = 1'b1; char_tick(1'b0, 1'b1, 1'b0, 1'b0);
      lines(2);
      checks++; if (INT !== 1'b1 || R52 !== 6'd0) begin
         errors++; $display("FAIL vrst_and_wrap got int %b r52 %0d exp int 1 r52 0", INT, R52); end
      vs_lvl = 1'b0; char_tick(1'b0, 1'b0, 1'b0, 1'b0);
      ack_strobe();
   endtask

   task automatic test_hsync_width();
      int widths [3] = '{14, 3, 2};
      for (int w = 0; w < 3; w++) begin
         char_tick(1'b0, 1'b0, 1'b0, 1'b0);
         for (int k = 0; k < widths[w] + 3; k++) begin
            char_tick(k < widths[w], 1'b0, 1'b0, 1'b0);
            checks++;
            if (HSYNC_OUT !== ((k >= 2) && (k <= 5) && (k < widths[w]))) begin
               errors++; $display("FAIL hs_width w%0d char %0d got %b exp %b", widths[w], k, HSYNC_OUT,
                                  ((k >= 2) && (k <= 5) && (k < widths[w])));
            end
         end
      end
   endtask

   task automatic test_mode();
      char_tick(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge CLOCK); MODE_WE = 1'b1; MODE_DI = 2'd2;
      @(negedge CLOCK); MODE_WE = 1'b0; MODE_DI = 2'd0;
      checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL mode_hold1 got %0d exp 0", MODE); end
      char_tick(1'b1, 1'b0, 1'b0, 1'b0);
      char_tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (MODE !== 2'd0) begin errors++; $display("FAIL mode_hold2 got %0d exp 0", MODE); end
      char_tick(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (MODE !== 2'd2) begin errors++; $display("FAIL mode_apply got %0d exp 2", MODE); end
      char_tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_vsync_width();
      int widths [2] = '{16, 31};
      for (int w = 0; w < 2; w++) begin
         vs_lvl = 1'b1; char_tick(1'b0, 1'b1, 1'b0, 1'b0);
         for (int i = 1; i <= widths[w]; i++) begin
            line();
            checks++; if (VSYNC_OUT !== (i < 26)) begin
               errors++; $display("FAIL vs_width w%0d line %0d got %b exp %b", widths[w], i, VSYNC_OUT, (i < 26)); end
         end
         vs_lvl = 1'b0; char_tick(1'b0, 1'b0, 1'b0, 1'b0);
         checks++; if (VSYNC_OUT !== 1'b0) begin
            errors++; $display("FAIL vs_end w%0d got %b exp 0", widths[w], VSYNC_OUT); end
      end
   endtask

   task automatic test_async_reset();
      lines(3);
      vs_lvl = 1'b1; char_tick(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLOCK); nRESET = 1'b0;
      #1;
      checks++; if (VSYNC_OUT !== 1'b0 || R52 !== 6'd0) begin
         errors++; $display("FAIL async_reset got v%b r52 %0d exp v0 r52 0", VSYNC_OUT, R52); end
      @(negedge CLOCK); nRESET = 1'b1; vs_lvl = 1'b0;
   endtask

   initial begin
      test_reset();
      test_int_period();
      test_vsync_int();
      test_vsync_low();
      test_ack_clr();
      test_hsync_width();
      test_mode();
      test_vsync_width();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
